// File: rtl/pc_control_unit_pkg.sv
// Shared constants and types for the fetch PC control path.
package pc_control_unit_pkg;
  localparam int PC_W = 16;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALTED} pc_state_e;
endpackage

// File: rtl/pc_target_adder.sv
// PC-relative target: base + (sext(imm) << 1), wrapping mod 2^PC_W.
module pc_target_adder #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
) (
  input  logic [PC_W-1:0]  base_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic [PC_W-1:0]  sum_o
);
  logic [PC_W-1:0] off;

  // Word offset becomes a byte offset; the sign fills the remaining upper bits.
  assign off   = {{(PC_W-IMM_W-1){imm_i[IMM_W-1]}}, imm_i, 1'b0};
  assign sum_o = base_i + off;
endmodule

// File: rtl/pc_control_unit.sv
// Fetch program counter with ID-stage branch redirect, IF/ID flush and HLT freeze.
module pc_control_unit #(
  parameter int              PC_W     = pc_control_unit_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              IMM_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             id_is_b,
  input  logic             id_is_br,
  input  logic             take_branch,
  input  logic [IMM_W-1:0] id_imm,
  input  logic [PC_W-1:0]  id_pc_plus2,
  input  logic [PC_W-1:0]  id_br_target,
  input  logic             if_is_hlt,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             flush_if_id,
  output logic             fetch_halted
);
  import pc_control_unit_pkg::*;

  pc_state_e       state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  pc_state_e       state_d;
  logic [PC_W-1:0] b_target, target;
  logic            redirect;

  pc_target_adder #(.PC_W(PC_W), .IMM_W(IMM_W)) u_b_adder (
    .base_i (id_pc_plus2),
    .imm_i  (id_imm),
    .sum_o  (b_target)
  );

  // B wins if decode ever raises both branch kinds.
  assign target   = id_is_b ? b_target : id_br_target;
  assign redirect = (state_q == RUN) && !stall && (id_is_b || id_is_br) && take_branch;

  assign pc           = pc_q;
  assign pc_plus2     = pc_q + PC_W'(2);
  assign flush_if_id  = !rst && redirect;
  assign fetch_halted = (state_q == HALTED);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (state_q == RUN && !stall) begin
      if (redirect) begin
        pc_d = target;
      end else if (if_is_hlt) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: sequencing, redirects, stall, halt, wrap, async reset.
module tb_pc_control_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        id_is_b = 1'b0;
  logic        id_is_br = 1'b0;
  logic        take_branch = 1'b0;
  logic [8:0]  id_imm = '0;
  logic [15:0] id_pc_plus2 = '0;
  logic [15:0] id_br_target = '0;
  logic        if_is_hlt = 1'b0;
  logic [15:0] pc, pc_plus2;
  logic        flush_if_id, fetch_halted;

  int checks = 0;
  int errors = 0;

  pc_control_unit #(.PC_W(16), .RESET_PC(16'h0000), .IMM_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .id_is_b      (id_is_b),
    .id_is_br     (id_is_br),
    .take_branch  (take_branch),
    .id_imm       (id_imm),
    .id_pc_plus2  (id_pc_plus2),
    .id_br_target (id_br_target),
    .if_is_hlt    (if_is_hlt),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .flush_if_id  (flush_if_id),
    .fetch_halted (fetch_halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(id_is_b && id_is_br)) else $error("id_is_b and id_is_br both high");

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; id_is_b = 0; id_is_br = 0; take_branch = 0;
    id_imm = '0; id_pc_plus2 = '0; id_br_target = '0; if_is_hlt = 0;
  endtask

  task automatic test_reset();
    id_is_b = 1; take_branch = 1; id_pc_plus2 = 16'h0040;
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", fetch_halted); end
    checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush_if_id); end
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp;
    exp = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== exp) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp); end
      checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL seq_flush[%0d] got %b exp 0", i, flush_if_id); end
      if (i < 3) tick();
      exp = exp + 16'h0002;
    end
  endtask

  task automatic test_b_branch();
    // pc is 0x0006 here
    id_is_b = 1; take_branch = 1; id_pc_plus2 = 16'h0010; id_imm = 9'h1FC;
    #1;
    checks++; if (flush_if_id !== 1'b1) begin errors++; $display("FAIL b_taken_flush got %b exp 1", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL b_taken_pc got %h exp 0008", pc); end
    take_branch = 0;
    #1;
    checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL b_nt_flush got %b exp 0", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h000A) begin errors++; $display("FAIL b_nt_pc got %h exp 000a", pc); end
    clear_inputs();
  endtask

  task automatic test_br_stall();
    id_is_br = 1; take_branch = 1; id_br_target = 16'h1234; stall = 1;
    #1;
    checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL br_stall_flush got %b exp 0", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h000A) begin errors++; $display("FAIL br_stall_pc got %h exp 000a", pc); end
    stall = 0;
    #1;
    checks++; if (flush_if_id !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL br_pc got %h exp 1234", pc); end
    clear_inputs();
  endtask

  task automatic test_halt();
    if_is_hlt = 1; id_is_b = 1; take_branch = 1; id_pc_plus2 = 16'h0100; id_imm = 9'h004;
    #1;
    checks++; if (flush_if_id !== 1'b1) begin errors++; $display("FAIL hlt_redir_flush got %b exp 1", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h0108) begin errors++; $display("FAIL hlt_redir_pc got %h exp 0108", pc); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL hlt_redir_halted got %b exp 0", fetch_halted); end
    id_is_b = 0; take_branch = 0; stall = 1;
    tick();
    checks++; if (pc !== 16'h0108) begin errors++; $display("FAIL hlt_stall_pc got %h exp 0108", pc); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL hlt_stall_halted got %b exp 0", fetch_halted); end
    stall = 0;
    tick();
    checks++; if (pc !== 16'h0108) begin errors++; $display("FAIL hlt_pc got %h exp 0108", pc); end
    checks++; if (fetch_halted !== 1'b1) begin errors++; $display("FAIL hlt_halted got %b exp 1", fetch_halted); end
    if_is_hlt = 0;
    tick();
    checks++; if (pc !== 16'h0108) begin errors++; $display("FAIL halted_hold_pc got %h exp 0108", pc); end
    id_is_br = 1; take_branch = 1; id_br_target = 16'h5555;
    #1;
    checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL halted_br_flush got %b exp 0", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h0108) begin errors++; $display("FAIL halted_br_pc got %h exp 0108", pc); end
    checks++; if (fetch_halted !== 1'b1) begin errors++; $display("FAIL halted_br_halted got %b exp 1", fetch_halted); end
    clear_inputs();
  endtask

  task automatic test_async_reset_halted();
    #2 rst = 1;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL arst_halt_pc got %h exp 0000", pc); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL arst_halt_halted got %b exp 0", fetch_halted); end
    tick();
    rst = 0;
    tick();
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL post_rst_pc got %h exp 0002", pc); end
  endtask

  task automatic test_wrap();
    id_is_br = 1; take_branch = 1; id_br_target = 16'hFFFC;
    tick();
    checks++; if (pc !== 16'hFFFC) begin errors++; $display("FAIL wrap_br_pc got %h exp fffc", pc); end
    id_is_br = 0; id_is_b = 1; id_pc_plus2 = 16'hFFFE; id_imm = 9'h001;
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_b_pc got %h exp 0000", pc); end
    id_is_b = 0; id_is_br = 1; id_br_target = 16'hFFFE;
    tick();
    checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_br2_pc got %h exp fffe", pc); end
    checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus2 got %h exp 0000", pc_plus2); end
    clear_inputs();
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_inc_pc got %h exp 0000", pc); end
  endtask

  task automatic test_async_reset_redirect();
    tick();
    id_is_br = 1; take_branch = 1; id_br_target = 16'h4444;
    #1;
    checks++; if (flush_if_id !== 1'b1) begin errors++; $display("FAIL pre_arst_flush got %b exp 1", flush_if_id); end
    #1 rst = 1;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL arst_redir_pc got %h exp 0000", pc); end
    checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL arst_redir_flush got %b exp 0", flush_if_id); end
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL arst_hold_pc got %h exp 0000", pc); end
    clear_inputs();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_b_branch();
    test_br_stall();
    test_halt();
    test_async_reset_halted();
    test_wrap();
    test_async_reset_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
- Owns the fetch program counter for the pipelined 16-bit core.
- Consumes the taken/not-taken decision produced by the condition evaluator in ID and redirects fetch for B (PC-relative) and BR (register) branches.
- Flushes the wrong-path instruction in IF/ID and freezes fetch once HLT is fetched.
- Sits between the ID-stage branch logic and instruction memory / IF-ID pipeline register.

Parameters:
- PC_W, 16, program counter and data width
- RESET_PC, 16'h0000, PC value loaded on reset
- IMM_W, 9, width of signed B-type offset field

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard unit hold; PC and state frozen, no redirect this cycle
- id_is_b  input  1  instruction in ID is B (opcode 1100)
- id_is_br  input  1  instruction in ID is BR (opcode 1101)
- take_branch  input  1  condition result for the ID instruction's ccc against current flags
- id_imm  input  IMM_W  signed word offset from the B instruction
- id_pc_plus2  input  PC_W  PC+2 of the instruction in ID
- id_br_target  input  PC_W  forwarded rs value for BR
- if_is_hlt  input  1  instruction currently fetched is HLT (opcode 1111)
- pc  output  PC_W  registered fetch address
- pc_plus2  output  PC_W  pc + 2 (combinational, mod 2^PC_W), fed to IF/ID for PCS and branches
- flush_if_id  output  1  combinational; squash IF/ID contents at next edge
- fetch_halted  output  1  registered; fetch frozen by HLT

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_PC, state=RUN, fetch_halted=0. flush_if_id=0 while rst is high.
- redirect = !stall & (id_is_b | id_is_br) & take_branch.
- target:
  - B: id_pc_plus2 + (sext(id_imm) << 1), truncated to PC_W (wrap-around permitted; 16'hFFFE+2 -> 16'h0000).
  - BR: id_br_target used unmodified.
- id_is_b and id_is_br are never both 1. If they are, B has priority, and the bench flags it as an assertion.
- States:
  - RUN: pc updates each edge with priority stall > redirect > hlt > increment.
    - stall: pc holds, state holds; this includes a pending if_is_hlt.
    - redirect: pc <= target, flush_if_id=1 this cycle. HLT in IF is wrong-path, so state stays RUN.
    - if_is_hlt (no stall, no redirect): pc holds, state <= HALTED.
    - otherwise: pc <= pc_plus2.
  - HALTED: pc frozen, fetch_halted=1. All inputs are ignored, including take_branch from ID (older instructions cannot be branches after HLT). Exit only via rst.
- Latency:
  - A redirect decided in cycle N makes the new pc visible in cycle N+1.
  - Exactly one instruction is squashed (one-cycle branch penalty).
- Not-taken branches cause no flush and no bubble.
- pc_plus2 wraps mod 2^PC_W.

Decomposition:
- Shared package holds:
  - opcode constants OP_B=4'b1100, OP_BR=4'b1101, OP_PCS=4'b1110, OP_HLT=4'b1111
  - PC_W
  - state enum {RUN, HALTED}
- Natural sub-module: pc_target_adder (sign-extend, shift, 16-bit add), reusable by the PCS path.
- Decode of id_is_b, id_is_br and if_is_hlt stays in the decode logic, not here.

Test Plan:
1. Reset release, no branches, no stall: pc sequence 0x0000, 0x0002, 0x0004, 0x0006; flush_if_id stays 0.
2. B taken with id_pc_plus2=0x0010, id_imm=9'h1FC (-4): flush_if_id=1 that cycle, next pc=0x0008. With take_branch=0, no flush and pc increments.
3. BR taken, id_br_target=0x1234, asserted together with stall=1: pc holds and no flush. Stall drops the next cycle: flush=1, then pc=0x1234.
4. if_is_hlt=1 with a taken B in ID the same cycle: redirect wins, state stays RUN. Later if_is_hlt alone: pc freezes and fetch_halted=1 next cycle; a later take_branch pulse is ignored.
5. Wrap: id_pc_plus2=0xFFFE, id_imm=+1 gives target 0x0000. pc=0xFFFE with no events gives next pc 0x0000.
6. rst asserted asynchronously mid-cycle during HALTED and during a redirect: pc=RESET_PC and fetch_halted=0 immediately, without waiting for a clock edge.
